// File: rtl/ccd_frame_sender_pkg.sv
// Shared types and constants for the CCD frame sender: FSM states, packet
// framing bytes and default sizing.
package ccd_frame_sender_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_SEQ,
    ST_LENH,
    ST_LENL,
    ST_RD,
    ST_RDW,
    ST_PIX,
    ST_CSUM,
    ST_TAIL
  } state_t;

  localparam logic [7:0] PKT_HDR0 = 8'hA5;
  localparam logic [7:0] PKT_HDR1 = 8'h5A;
  localparam logic [7:0] PKT_TAIL = 8'h0D;

  localparam int HDR_LEN     = 5;
  localparam int PIXELS_DEF  = 1024;
  localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/ccd_frame_sender_if.sv
// Pixel FIFO read port plus UART byte stream, bundled as seen by the sender.
interface ccd_frame_sender_if;

  logic       rdreq;
  logic [7:0] q;
  logic       rdempty;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rdreq, tx_data, tx_valid,
    input  q, rdempty, tx_ready
  );

  modport slave (
    input  rdreq, tx_data, tx_valid,
    output q, rdempty, tx_ready
  );

endinterface

// File: rtl/ccd_pkt_checksum.sv
// 8-bit wrap-around byte accumulator with synchronous clear and add enable.
module ccd_pkt_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/ccd_frame_sender.sv
// Drains one frame from the pixel FIFO per serialsend_flag rising edge and
// streams it to the UART as HDR0 HDR1 SEQ LENH LENL pixels CSUM TAIL.
module ccd_frame_sender
  import ccd_frame_sender_pkg::*;
#(
  parameter int         PIXELS  = PIXELS_DEF,
  parameter logic [7:0] HDR0    = PKT_HDR0,
  parameter logic [7:0] HDR1    = PKT_HDR1,
  parameter logic [7:0] TAIL    = PKT_TAIL,
  parameter int         TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serialsend_flag,
  ccd_frame_sender_if.master  bus,
  output logic                busy,
  output logic                err_underrun,
  output logic [7:0]          frame_seq
);

  localparam int              EW         = $clog2(TIMEOUT + 1);
  localparam logic [15:0]     LEN        = 16'(PIXELS);
  localparam logic [11:0]     LAST_PIX   = 12'(PIXELS - 1);
  localparam logic [EW-1:0]   EMPTY_LAST = EW'(TIMEOUT - 1);

  state_t          state;
  logic            flag_d;
  logic            pad;
  logic [11:0]     pix_cnt;
  logic [EW-1:0]   empty_cnt;
  logic [7:0]      csum;
  logic            xfer;
  logic            start_edge;
  logic            csum_clear;
  logic            csum_add;

  assign xfer       = bus.tx_valid && bus.tx_ready;
  assign start_edge = serialsend_flag && !flag_d;
  assign csum_clear = (state == ST_IDLE) && start_edge;
  assign csum_add   = xfer && (state inside {ST_SEQ, ST_LENH, ST_LENL, ST_PIX});

  // Read request is issued in the RD cycle itself so q is valid during RDW;
  // gating on rdempty keeps the FIFO from ever being read while empty.
  assign bus.rdreq = (state == ST_RD) && !bus.rdempty;

  ccd_pkt_checksum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clear  (csum_clear),
    .add_en (csum_add),
    .din    (bus.tx_data),
    .sum    (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      flag_d       <= 1'b0;
      busy         <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      err_underrun <= 1'b0;
      frame_seq    <= 8'h00;
      pad          <= 1'b0;
      pix_cnt      <= 12'd0;
      empty_cnt    <= '0;
    end else begin
      flag_d       <= serialsend_flag;
      err_underrun <= 1'b0;
      case (state)
        ST_IDLE: if (start_edge) begin
          state        <= ST_HDR0;
          busy         <= 1'b1;
          bus.tx_data  <= HDR0;
          bus.tx_valid <= 1'b1;
        end
        ST_HDR0: if (xfer) begin
          state       <= ST_HDR1;
          bus.tx_data <= HDR1;
        end
        ST_HDR1: if (xfer) begin
          state       <= ST_SEQ;
          bus.tx_data <= frame_seq;
        end
        ST_SEQ: if (xfer) begin
          state       <= ST_LENH;
          bus.tx_data <= LEN[15:8];
        end
        ST_LENH: if (xfer) begin
          state       <= ST_LENL;
          bus.tx_data <= LEN[7:0];
        end
        ST_LENL: if (xfer) begin
          state        <= ST_RD;
          bus.tx_valid <= 1'b0;
        end
        // Starvation counter only advances while waiting here; hitting the
        // limit switches the rest of the frame to zero padding.
        ST_RD: begin
          if (!bus.rdempty) begin
            empty_cnt <= '0;
            state     <= ST_RDW;
          end else if (empty_cnt == EMPTY_LAST) begin
            pad          <= 1'b1;
            err_underrun <= 1'b1;
            bus.tx_data  <= 8'h00;
            bus.tx_valid <= 1'b1;
            state        <= ST_PIX;
          end else begin
            empty_cnt <= empty_cnt + 1'b1;
          end
        end
        ST_RDW: begin
          bus.tx_data  <= bus.q;
          bus.tx_valid <= 1'b1;
          state        <= ST_PIX;
        end
        ST_PIX: if (xfer) begin
          pix_cnt <= pix_cnt + 12'd1;
          if (pix_cnt == LAST_PIX) begin
            state       <= ST_CSUM;
            bus.tx_data <= csum + bus.tx_data;
          end else if (pad) begin
            bus.tx_data <= 8'h00;
          end else begin
            state        <= ST_RD;
            bus.tx_valid <= 1'b0;
          end
        end
        ST_CSUM: if (xfer) begin
          state       <= ST_TAIL;
          bus.tx_data <= TAIL;
        end
        ST_TAIL: if (xfer) begin
          state        <= ST_IDLE;
          bus.tx_valid <= 1'b0;
          busy         <= 1'b0;
          frame_seq    <= frame_seq + 8'd1;
          pad          <= 1'b0;
          pix_cnt      <= 12'd0;
          empty_cnt    <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccd_frame_sender.sv
// Self-checking bench: a 1024-pixel sender fed by a queue-style FIFO model
// and a 5-pixel sender used for the sequence-number wrap.
module tb_ccd_frame_sender;

  localparam int NPIX_A = 1024;
  localparam int NPIX_B = 5;

  typedef struct {
    int avail;
    int ready_mode;
    bit ramp;
    bit mid_edge;
    int exp_uf;
    int exp_csum;
    int exp_gap;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       flag_a = 1'b0;
  logic       flag_b = 1'b0;
  logic       busy_a, busy_b, uf_a, uf_b;
  logic [7:0] seq_a, seq_b;

  ccd_frame_sender_if a_if ();
  ccd_frame_sender_if b_if ();

  ccd_frame_sender #(.PIXELS(NPIX_A), .TIMEOUT(16)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .serialsend_flag (flag_a),
    .bus             (a_if),
    .busy            (busy_a),
    .err_underrun    (uf_a),
    .frame_seq       (seq_a)
  );

  ccd_frame_sender #(.PIXELS(NPIX_B), .TIMEOUT(16)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .serialsend_flag (flag_b),
    .bus             (b_if),
    .busy            (busy_b),
    .err_underrun    (uf_b),
    .frame_seq       (seq_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // FIFO model for sender A: memory filled by the stimulus, read pointer here.
  logic [7:0] fifo_mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         overread = 0;
  logic       flush_req = 1'b0;

  always @(posedge clk) begin
    int nrd;
    nrd = rd_ptr;
    if (flush_req) begin
      nrd = wr_ptr;
    end else if (a_if.rdreq === 1'b1) begin
      if (a_if.rdempty !== 1'b0 || rd_ptr == wr_ptr) begin
        overread <= overread + 1;
      end else begin
        a_if.q <= fifo_mem[rd_ptr % 4096];
        nrd = rd_ptr + 1;
      end
    end
    rd_ptr       <= nrd;
    a_if.rdempty <= (nrd == wr_ptr);
  end

  // Sender B's FIFO never runs dry and returns a running byte count.
  int b_rd = 0;
  always @(posedge clk) begin
    b_if.rdempty <= 1'b0;
    if (b_if.rdreq === 1'b1) begin
      b_if.q <= 8'(b_rd);
      b_rd   <= b_rd + 1;
    end
  end

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int         stab_viol = 0;
  int         uf_pulses = 0;
  int         uf_gap = 0;
  int         last_x = 0;
  int         mcyc = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    if (hold_pend && !rst && (a_if.tx_valid !== 1'b1 || a_if.tx_data !== hold_data))
      stab_viol <= stab_viol + 1;
    hold_pend <= (a_if.tx_valid === 1'b1) && !a_if.tx_ready && !rst;
    hold_data <= a_if.tx_data;
    if (!rst && a_if.tx_valid === 1'b1 && a_if.tx_ready) begin
      rx_a.push_back(a_if.tx_data);
      last_x <= mcyc;
    end
    if (!rst && uf_a === 1'b1) begin
      uf_pulses <= uf_pulses + 1;
      uf_gap    <= mcyc - last_x;
    end
    if (!rst && b_if.tx_valid === 1'b1 && b_if.tx_ready)
      rx_b.push_back(b_if.tx_data);
  end

  // Reference packet: framing, length, pixels padded with zeros, mod-256 sum.
  logic [7:0] frame_pix[$];
  logic [7:0] exp_pkt[$];

  task automatic build_packet(input int seq, input int npix);
    int sum;
    exp_pkt = {};
    exp_pkt.push_back(8'hA5);
    exp_pkt.push_back(8'h5A);
    exp_pkt.push_back(8'(seq));
    exp_pkt.push_back(8'(npix / 256));
    exp_pkt.push_back(8'(npix % 256));
    sum = seq + npix / 256 + npix % 256;
    for (int i = 0; i < npix; i++) begin
      int b;
      b = (i < frame_pix.size()) ? int'(frame_pix[i]) : 0;
      exp_pkt.push_back(8'(b));
      sum = sum + b;
    end
    exp_pkt.push_back(8'(sum % 256));
    exp_pkt.push_back(8'h0D);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] rx_a_at(input int idx);
    return (idx < rx_a.size()) ? 32'(rx_a[idx]) : 32'hFFFF_FFFF;
  endfunction

  int exp_seq_a = 0;

  task automatic applyStimulus(input vec_t v, input string tag);
    int start, uf0, sv0, or0, cyc, nbad, got;
    bit edge_done;
    @(negedge clk);
    frame_pix = {};
    for (int i = 0; i < v.avail; i++) begin
      logic [7:0] b;
      b = v.ramp ? 8'(i) : 8'($urandom);
      frame_pix.push_back(b);
      fifo_mem[(wr_ptr + i) % 4096] = b;
    end
    wr_ptr = wr_ptr + v.avail;
    start = rx_a.size();
    uf0 = uf_pulses;
    sv0 = stab_viol;
    or0 = overread;
    build_packet(exp_seq_a, NPIX_A);
    flag_a = 1'b1;
    @(negedge clk);
    flag_a = 1'b0;
    cyc = 0;
    edge_done = 1'b0;
    while (rx_a.size() - start < exp_pkt.size() && cyc < 30000) begin
      case (v.ready_mode)
        1:       a_if.tx_ready = (cyc % 3 == 2);
        2:       a_if.tx_ready = 1'($urandom_range(0, 1));
        default: a_if.tx_ready = 1'b1;
      endcase
      if (v.mid_edge) begin
        if (flag_a) flag_a = 1'b0;
        else if (!edge_done && rx_a.size() - start >= 300) begin
          flag_a    = 1'b1;
          edge_done = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    flag_a = 1'b0;
    a_if.tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    got = rx_a.size() - start;
    nbad = 0;
    for (int i = 0; i < exp_pkt.size(); i++)
      if (i >= got || rx_a[start + i] !== exp_pkt[i]) nbad++;
    checkOutput({tag, " byte_count"}, got, exp_pkt.size());
    checkOutput({tag, " hdr0"}, rx_a_at(start), 32'hA5);
    checkOutput({tag, " seq_byte"}, rx_a_at(start + 2), 32'(8'(exp_seq_a)));
    checkOutput({tag, " bad_bytes"}, nbad, 0);
    checkOutput({tag, " csum"}, rx_a_at(start + NPIX_A + 5),
                (v.exp_csum >= 0) ? 32'(v.exp_csum) : 32'(exp_pkt[NPIX_A + 5]));
    checkOutput({tag, " underrun_pulses"}, uf_pulses - uf0, v.exp_uf);
    if (v.exp_gap > 0) checkOutput({tag, " underrun_delay"}, uf_gap, v.exp_gap);
    checkOutput({tag, " unstable_holds"}, stab_viol - sv0, 0);
    checkOutput({tag, " overreads"}, overread - or0, 0);
    checkOutput({tag, " busy_after"}, busy_a, 0);
    exp_seq_a = (exp_seq_a + 1) % 256;
    checkOutput({tag, " frame_seq"}, seq_a, exp_seq_a);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t rv;
    int   start, cyc, nbad;

    vecs[0] = '{1024, 0, 1'b1, 1'b0, 0, 'h04, 0};
    vecs[1] = '{1024, 1, 1'b1, 1'b0, 0, 'h05, 0};
    vecs[2] = '{1000, 0, 1'b1, 1'b0, 1, 'h32, 17};
    vecs[3] = '{1024, 2, 1'b0, 1'b1, 0, -1, 0};
    vecs[4] = '{int'($urandom_range(900, 1023)), 2, 1'b0, 1'b0, 1, -1, 0};
    vecs[5] = '{1024, 1, 1'b0, 1'b0, 0, -1, 0};

    a_if.tx_ready = 1'b1;
    b_if.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset tx_valid", a_if.tx_valid, 0);
    checkOutput("reset tx_data", a_if.tx_data, 0);
    checkOutput("reset rdreq", a_if.rdreq, 0);
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset err_underrun", uf_a, 0);
    checkOutput("reset frame_seq", seq_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Abort a packet partway through the pixels, then start cleanly.
    @(negedge clk);
    for (int i = 0; i < NPIX_A; i++) fifo_mem[(wr_ptr + i) % 4096] = 8'(i);
    wr_ptr = wr_ptr + NPIX_A;
    start = rx_a.size();
    flag_a = 1'b1;
    @(negedge clk);
    flag_a = 1'b0;
    cyc = 0;
    while (rx_a.size() - start < 305 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort reached_pixel_300", (rx_a.size() - start >= 305), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort tx_valid", a_if.tx_valid, 0);
    checkOutput("abort rdreq", a_if.rdreq, 0);
    checkOutput("abort busy", busy_a, 0);
    checkOutput("abort frame_seq", seq_a, 0);
    rst = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    exp_seq_a = 0;
    rv = '{1024, 0, 1'b0, 1'b0, 0, -1, 0};
    applyStimulus(rv, "post_abort");

    // Sender B: 257 short frames to walk the sequence number through a wrap.
    for (int k = 0; k < 257; k++) begin
      frame_pix = {};
      for (int j = 0; j < NPIX_B; j++) frame_pix.push_back(8'(NPIX_B * k + j));
      build_packet(k % 256, NPIX_B);
      start = rx_b.size();
      flag_b = 1'b1;
      @(negedge clk);
      flag_b = 1'b0;
      cyc = 0;
      while (rx_b.size() - start < exp_pkt.size() && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      repeat (2) @(negedge clk);
      nbad = 0;
      for (int i = 0; i < exp_pkt.size(); i++)
        if (start + i >= rx_b.size() || rx_b[start + i] !== exp_pkt[i]) nbad++;
      checkOutput($sformatf("wrap frame%0d bad_bytes", k), nbad, 0);
      checkOutput($sformatf("wrap frame%0d frame_seq", k), seq_b, (k + 1) % 256);
    end
    checkOutput("wrap busy_after", busy_b, 0);
    checkOutput("wrap err_underrun_idle", uf_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
